rle_encoder_gen: RTL and testbench
==================================

# rle_encoder_gen

Parametrised run-length encoder, next generation of the team's RLE frame compressor. It reads a plaintext frame of `message_size` bytes from the shared single-port DPSRAM (port A) and writes (symbol, count) pairs packed into 32-bit words at `rle_addr`. New over the previous generation:
- configurable count width, with run saturation and split;
- arbitrary (non-multiple-of-4) message lengths;
- explicit handling of a zero-length frame;
- a `busy` status output.

## Interface
Parameters:
- ADDR_W, 16, DPSRAM byte-address width driven on `port_A_addr`.
- CNT_W, 8, run-count field width; legal values 8 or 24 only (pair width 16 or 32).

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous, active-low reset
- start  in  1  begin compressing a frame; sampled only when not busy
- message_addr  in  32  byte address of the plaintext; low ADDR_W bits used; word aligned
- message_size  in  32  plaintext length in bytes
- rle_addr  in  32  byte address of the output; low ADDR_W bits used; word aligned
- rle_size  out  32  bytes written so far, always a multiple of 4
- done  out  1  frame complete; level signal
- busy  out  1  frame in progress
- port_A_clk  out  1  equals clk
- port_A_addr  out  ADDR_W  DPSRAM byte address
- port_A_we  out  1  write enable
- port_A_data_in  out  32  write data
- port_A_data_out  in  32  read data

## Operation
- Byte order is little-endian: byte k of a word is bits [8k+7:8k].
- A pair is {symbol[7:0], count[CNT_W-1:0]}, with count in the LSBs. Count equals the run length, from 1 to 2^CNT_W-1.
- CNT_W=8 packs two pairs per word: the first pair in [15:0], the second in [31:16].
- CNT_W=24 packs one pair per word.
- State machine:
  - IDLE: on `start`, latch addresses and size; clear rle_size, done and all internal state; go to RD.
  - If message_size==0, go directly to FIN instead.
- RD: drive the read address with we=0, then go to RW.
- RW: capture port_A_data_out into the shift register, then go to SCAN.
- SCAN: consume one byte per cycle.
  - A byte equal to the current symbol with count < max increments the count.
  - Otherwise (different symbol or saturated count) emit the current pair to the packer and start a new run with count 1.
  - After the 4th byte of a word, or when the total consumed equals message_size, go to RD or FLUSH respectively.
  - Whenever the packer holds a full word, go to WR before consuming further bytes.
- WR: one cycle with we=1, addr=write pointer, and data=packed word. Then write pointer += 4 and rle_size += 4. Return to the calling state (SCAN or FLUSH).
- FLUSH: emit the final pending pair. If the packer is partially filled, pad the empty upper half with zeros and write it via WR. Then go to FIN.
- FIN: one cycle, then IDLE with done=1.
- `done` stays 1 until the next accepted `start`.
- `busy` is 1 in every state except IDLE.
- Bytes beyond message_size in the last word are ignored.
- `start` while busy is ignored.
- Reset mid-operation: all registers return to reset values immediately. No further writes occur; any partial frame is abandoned.
- All arithmetic wraps modulo its width. Address wrap at 2^ADDR_W is not checked.

## Timing
- Reset values:
  - port_A_we=0, port_A_addr=0, port_A_data_in=0;
  - rle_size=0, done=0, busy=0; state IDLE.
- Read latency: the address is driven in RD; data is sampled at the clock edge ending RW (1 wait cycle).
- Per input word: 2 cycles (RD, RW) plus up to 4 SCAN cycles, plus 1 cycle per output word written.
- `done` rises 1 cycle after FIN, i.e. 2 cycles after the final WR. For a zero-length frame, `done` rises 2 cycles after `start`.
- All outputs are registered except port_A_clk. port_A_addr is multiplexed from registered read/write pointers by registered `we`.

## Structure
- Package rle_pkg holds:
  - the state enum (IDLE, RD, RW, SCAN, WR, FLUSH, FIN);
  - localparam WORD_W=32 and SYM_W=8;
  - a function giving pairs per word from CNT_W.
- Sub-module rle_pair_packer: accepts a pair-valid strobe and pair data, accumulates pairs into a word, and raises `full`. It provides flush/pad and clear inputs.
- Top level holds the FSM, read/write pointers, byte shift register, run counter and total counter.

## Test plan
- CNT_W=8, bytes 11 11 11 22 22 22 22 22, size 8 -> one write 0x2205_1103 at rle_addr; rle_size=4; done=1.
- CNT_W=8, bytes AA BB CC CC, size 4 -> writes 0xBB01_AA01, then 0x0000_CC02; rle_size=8.
- CNT_W=8, 300 bytes of 5A -> single write 0x5A2D_5AFF (255 then 45); rle_size=4.
- CNT_W=8, size 5, second word 0x9999_9977 -> only byte 77 is used for the second word. The final pair is (77, n), with n counted across the word boundary.
- message_size=0 -> no we pulse; done=1 two cycles after start; rle_size=0.
- CNT_W=24, bytes 01 02 02 02 -> writes 0x0100_0001, then 0x0200_0003. Then rerun and assert nreset mid-SCAN -> outputs return to reset values and no write occurs after the reset.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE frame compressor.
package rle_pkg;

    localparam int WORD_W = 32;
    localparam int SYM_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RW,
        SCAN,
        WR,
        FLUSH,
        FIN
    } state_t;

    // Pairs per output word: 2 for a 16-bit pair, 1 for a 32-bit pair.
    function automatic int pairs_per_word(input int cnt_w);
        return WORD_W / (SYM_W + cnt_w);
    endfunction

endpackage

// File: rtl/rle_pair_packer.sv
// Packs (symbol,count) pairs LSB-first into a 32-bit word and flags it full.
// One-cycle update; i_pad forces full with zero upper slots, i_clear empties it.
module rle_pair_packer
    import rle_pkg::*;
#(
    parameter int PAIR_W = 16,
    parameter int PPW    = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              i_pair_vld,
    input  logic [PAIR_W-1:0] i_pair_dat,
    input  logic              i_pad,
    input  logic              i_clear,
    output logic [WORD_W-1:0] o_word,
    output logic              o_full,
    output logic              o_last_slot
);

    localparam logic [1:0] PPW_L  = 2'(PPW);
    localparam logic [1:0] LAST_L = 2'(PPW - 1);

    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_fill;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_word <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_fill <= '0;
        end else begin
            for (int i = 0; i < PPW; i++) begin
                if (i_pair_vld && (r_fill == 2'(i))) begin
                    r_word[i*PAIR_W +: PAIR_W] <= i_pair_dat;
                end
            end
            // Padding leaves the unused upper slots at their cleared zero value.
            if (i_pad) begin
                r_fill <= PPW_L;
            end else if (i_pair_vld) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign o_word      = r_word;
    assign o_full      = (r_fill == PPW_L);
    assign o_last_slot = (r_fill == LAST_L);

endmodule

// File: rtl/rle_encoder_gen.sv
// Run-length encoder: reads a byte frame from DPSRAM port A, writes packed (symbol,count) words.
// 2 cycles per input word read + 1 per byte + 1 per output word; no backpressure, memory is fixed-latency.
module rle_encoder_gen
    import rle_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
    input  logic [31:0]       rle_addr,
    output logic [31:0]       rle_size,
    output logic              done,
    output logic              busy,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    localparam int              PPW     = pairs_per_word(CNT_W);
    localparam int              PAIR_W  = SYM_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

    state_t             r_state, r_ret;
    logic [ADDR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [31:0]        r_size, r_total, r_shift, r_rle_size;
    logic [1:0]         r_bidx;
    logic [SYM_W-1:0]   r_sym;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run, r_we, r_done, r_busy;

    state_t             w_next, w_ret, w_dest;
    logic               w_pair_vld, w_pad, w_clear;
    logic               w_same, w_emit, w_end;
    logic               w_full, w_last_slot;
    logic [SYM_W-1:0]   w_byte;
    logic [31:0]        w_total_inc, w_word;
    logic               w_unused_bits;

    assign w_unused_bits = ^{message_addr[31:ADDR_W], rle_addr[31:ADDR_W], w_full};

    assign w_byte      = r_shift[SYM_W-1:0];
    assign w_total_inc = r_total + 32'd1;
    assign w_end       = (w_total_inc == r_size);
    assign w_same      = r_run && (w_byte == r_sym) && (r_cnt != CNT_MAX);
    assign w_emit      = r_run && !w_same;
    // The frame end takes priority over the word end when both coincide.
    assign w_dest      = w_end ? FLUSH : ((r_bidx == 2'd3) ? RD : SCAN);

    always_comb begin
        w_next     = r_state;
        w_ret      = r_ret;
        w_pair_vld = 1'b0;
        w_pad      = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = (message_size == 32'd0) ? FIN : RD;
                end
            end
            RD:   w_next = RW;
            RW:   w_next = SCAN;
            SCAN: begin
                w_pair_vld = w_emit;
                if (w_emit && w_last_slot) begin
                    w_next = WR;
                    w_ret  = w_dest;
                end else begin
                    w_next = w_dest;
                end
            end
            WR: begin
                w_clear = 1'b1;
                w_next  = r_ret;
            end
            FLUSH: begin
                w_pair_vld = 1'b1;
                w_pad      = 1'b1;
                w_next     = WR;
                w_ret      = FIN;
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= IDLE;
            r_ret      <= IDLE;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_size     <= '0;
            r_total    <= '0;
            r_shift    <= '0;
            r_rle_size <= '0;
            r_bidx     <= '0;
            r_sym      <= '0;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret;
            r_we    <= (w_next == WR);
            r_busy  <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rd_ptr   <= message_addr[ADDR_W-1:0];
                        r_wr_ptr   <= rle_addr[ADDR_W-1:0];
                        r_size     <= message_size;
                        r_total    <= '0;
                        r_shift    <= '0;
                        r_bidx     <= '0;
                        r_sym      <= '0;
                        r_cnt      <= '0;
                        r_run      <= 1'b0;
                        r_rle_size <= '0;
                        r_done     <= 1'b0;
                    end
                end
                RW: begin
                    r_shift  <= port_A_data_out;
                    r_bidx   <= '0;
                    r_rd_ptr <= r_rd_ptr + STEP;
                end
                SCAN: begin
                    r_shift <= {8'h00, r_shift[31:8]};
                    r_bidx  <= r_bidx + 2'd1;
                    r_total <= w_total_inc;
                    r_run   <= 1'b1;
                    if (w_same) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_sym <= w_byte;
                        r_cnt <= CNT_ONE;
                    end
                end
                WR: begin
                    r_wr_ptr   <= r_wr_ptr + STEP;
                    r_rle_size <= r_rle_size + 32'd4;
                end
                FIN:     r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    rle_pair_packer #(
        .PAIR_W (PAIR_W),
        .PPW    (PPW)
    ) u_packer (
        .clk         (clk),
        .nreset      (nreset),
        .i_pair_vld  (w_pair_vld),
        .i_pair_dat  ({r_sym, r_cnt}),
        .i_pad       (w_pad),
        .i_clear     (w_clear),
        .o_word      (w_word),
        .o_full      (w_full),
        .o_last_slot (w_last_slot)
    );

    assign port_A_clk     = clk;
    assign port_A_we      = r_we;
    assign port_A_addr    = r_we ? r_wr_ptr : r_rd_ptr;
    assign port_A_data_in = w_word;
    assign rle_size       = r_rle_size;
    assign done           = r_done;
    assign busy           = r_busy;

endmodule

// File: tb/tb_rle_encoder_gen.sv
// Directed bench for rle_encoder_gen with 8-bit and 24-bit count instances and DPSRAM models.
module tb_rle_encoder_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset;
    logic        start8, start24;
    logic [31:0] maddr, msize, raddr;

    logic [31:0] rsz8, rsz24, din8, din24, dout8, dout24;
    logic        done8, done24, busy8, busy24, we8, we24, pclk8, pclk24;
    logic [15:0] addr8, addr24;

    logic [31:0] mem8  [0:255];
    logic [31:0] mem24 [0:255];
    logic [31:0] wa8[$], wd8[$], wa24[$], wd24[$];

    int n_cmp = 0;
    int n_bad = 0;

    rle_encoder_gen #(.ADDR_W(16), .CNT_W(8)) u8 (
        .clk(clk), .nreset(nreset), .start(start8),
        .message_addr(maddr), .message_size(msize), .rle_addr(raddr),
        .rle_size(rsz8), .done(done8), .busy(busy8),
        .port_A_clk(pclk8), .port_A_addr(addr8), .port_A_we(we8),
        .port_A_data_in(din8), .port_A_data_out(dout8)
    );

    rle_encoder_gen #(.ADDR_W(16), .CNT_W(24)) u24 (
        .clk(clk), .nreset(nreset), .start(start24),
        .message_addr(maddr), .message_size(msize), .rle_addr(raddr),
        .rle_size(rsz24), .done(done24), .busy(busy24),
        .port_A_clk(pclk24), .port_A_addr(addr24), .port_A_we(we24),
        .port_A_data_in(din24), .port_A_data_out(dout24)
    );

    // Synchronous-read single-port memories that also log every write.
    always @(posedge clk) begin
        if (we8) begin
            mem8[addr8[9:2]] <= din8;
            wa8.push_back({16'h0, addr8});
            wd8.push_back(din8);
        end
        dout8 <= mem8[addr8[9:2]];
        if (we24) begin
            mem24[addr24[9:2]] <= din24;
            wa24.push_back({16'h0, addr24});
            wd24.push_back(din24);
        end
        dout24 <= mem24[addr24[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a frame on the chosen instance and waits (bounded) for done.
    task automatic run(input bit w24, input string tag, input logic [31:0] size, input logic [31:0] ra);
        wa8.delete(); wd8.delete(); wa24.delete(); wd24.delete();
        maddr = 32'h0;
        msize = size;
        raddr = ra;
        @(negedge clk);
        if (w24) start24 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        start24 = 1'b0;
        check({tag, "_busy_run"}, {31'h0, w24 ? busy24 : busy8}, 32'd1);
        check({tag, "_done_clr"}, {31'h0, w24 ? done24 : done8}, 32'd0);
        for (int c = 0; c < 3000; c++) begin
            if ((w24 ? done24 : done8) === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_done"}, {31'h0, w24 ? done24 : done8}, 32'd1);
        check({tag, "_busy_end"}, {31'h0, w24 ? busy24 : busy8}, 32'd0);
    endtask

    initial begin
        nreset  = 1'b0;
        start8  = 1'b0;
        start24 = 1'b0;
        maddr   = '0;
        msize   = '0;
        raddr   = '0;
        for (int i = 0; i < 256; i++) begin
            mem8[i]  = '0;
            mem24[i] = '0;
        end
        repeat (3) @(negedge clk);

        check("rst_we",    {31'h0, we8},   32'd0);
        check("rst_addr",  {16'h0, addr8}, 32'd0);
        check("rst_din",   din8,           32'd0);
        check("rst_rsz",   rsz8,           32'd0);
        check("rst_done",  {31'h0, done8}, 32'd0);
        check("rst_busy",  {31'h0, busy8}, 32'd0);
        check("rst_busy24", {31'h0, busy24}, 32'd0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Two runs, one word of two pairs.
        mem8[0] = 32'h2211_1111;
        mem8[1] = 32'h2222_2222;
        run(1'b0, "t1", 32'd8, 32'h200);
        check("t1_rsz",  rsz8, 32'd4);
        check("t1_nwr",  32'(wa8.size()), 32'd1);
        check("t1_wa0",  wa8[0], 32'h200);
        check("t1_wd0",  wd8[0], 32'h2205_1103);

        // Packer fills mid-word, final pair padded.
        mem8[0] = 32'hCCCC_BBAA;
        run(1'b0, "t2", 32'd4, 32'h200);
        check("t2_rsz",  rsz8, 32'd8);
        check("t2_nwr",  32'(wa8.size()), 32'd2);
        check("t2_wa0",  wa8[0], 32'h200);
        check("t2_wd0",  wd8[0], 32'hBB01_AA01);
        check("t2_wa1",  wa8[1], 32'h204);
        check("t2_wd1",  wd8[1], 32'h0000_CC02);

        // Saturation: 300 identical bytes split as 255 + 45.
        for (int i = 0; i < 75; i++) mem8[i] = 32'h5A5A_5A5A;
        run(1'b0, "t3", 32'd300, 32'h300);
        check("t3_rsz",  rsz8, 32'd4);
        check("t3_nwr",  32'(wa8.size()), 32'd1);
        check("t3_wa0",  wa8[0], 32'h300);
        check("t3_wd0",  wd8[0], 32'h5A2D_5AFF);

        // Odd length: run spans the word boundary, trailing 99s ignored.
        mem8[0] = 32'h7777_7733;
        mem8[1] = 32'h9999_9977;
        run(1'b0, "t4", 32'd5, 32'h200);
        check("t4_rsz",  rsz8, 32'd4);
        check("t4_nwr",  32'(wa8.size()), 32'd1);
        check("t4_wd0",  wd8[0], 32'h7704_3301);

        // Zero-length frame: done exactly two cycles after start.
        wa8.delete(); wd8.delete();
        msize = 32'd0;
        raddr = 32'h200;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("t5_busy",   {31'h0, busy8}, 32'd1);
        check("t5_done0",  {31'h0, done8}, 32'd0);
        @(negedge clk);
        check("t5_done1",  {31'h0, done8}, 32'd1);
        check("t5_idle",   {31'h0, busy8}, 32'd0);
        check("t5_rsz",    rsz8, 32'd0);
        check("t5_nwr",    32'(wa8.size()), 32'd0);

        // 24-bit counts: one pair per word.
        mem24[0] = 32'h0202_0201;
        run(1'b1, "t6", 32'd4, 32'h200);
        check("t6_rsz",  rsz24, 32'd8);
        check("t6_nwr",  32'(wa24.size()), 32'd2);
        check("t6_wa0",  wa24[0], 32'h200);
        check("t6_wd0",  wd24[0], 32'h0100_0001);
        check("t6_wa1",  wa24[1], 32'h204);
        check("t6_wd1",  wd24[1], 32'h0200_0003);

        // Rerun and reset while scanning, one cycle before the first write.
        wa24.delete(); wd24.delete();
        @(negedge clk);
        start24 = 1'b1;
        @(negedge clk);
        start24 = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_busy_pre", {31'h0, busy24}, 32'd1);
        nreset = 1'b0;
        #1;
        check("t7_we",    {31'h0, we24},   32'd0);
        check("t7_addr",  {16'h0, addr24}, 32'd0);
        check("t7_din",   din24,           32'd0);
        check("t7_busy",  {31'h0, busy24}, 32'd0);
        check("t7_done",  {31'h0, done24}, 32'd0);
        check("t7_rsz",   rsz24,           32'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (20) @(negedge clk);
        check("t7_nwr",      32'(wa24.size()), 32'd0);
        check("t7_busy_end", {31'h0, busy24}, 32'd0);
        check("t7_done_end", {31'h0, done24}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
